// File: rtl/calc_pkg.sv
// Shared calculator definitions: token codes, default buffer geometry and the
// expression-buffer FSM state type.
package calc_pkg;

   localparam int DEFAULT_WIDTH = 8;
   localparam int DEFAULT_DEPTH = 32;

   localparam logic [7:0] DIGIT_0    = 8'h00;
   localparam logic [7:0] DIGIT_9    = 8'h09;
   localparam logic [7:0] OP_ADD     = 8'h2B;
   localparam logic [7:0] OP_SUB     = 8'h2D;
   localparam logic [7:0] OP_MUL     = 8'h2A;
   localparam logic [7:0] OP_DIV     = 8'h2F;
   localparam logic [7:0] OP_LB      = 8'h28;
   localparam logic [7:0] OP_RB      = 8'h29;
   localparam logic [7:0] OP_DECIMAL = 8'h2E;
   localparam logic [7:0] OP_COMMA   = 8'h2C;
   localparam logic [7:0] CONST_PI   = 8'h50;
   localparam logic [7:0] CONST_E    = 8'h51;
   localparam logic [7:0] FN_SIN     = 8'h60;
   localparam logic [7:0] FN_COS     = 8'h61;
   localparam logic [7:0] FN_SQRT    = 8'h62;

   typedef enum logic {ST_IDLE, ST_EVAL} state_e;

   function automatic logic is_digit(input logic [7:0] tok);
      return tok <= DIGIT_9;
   endfunction

endpackage

// File: rtl/expr_buffer_if.sv
// Encoder/evaluator-facing bundle of the expression buffer; the buffer is the
// slave, the keyboard encoder plus evaluator together act as master.
interface expr_buffer_if #(
   parameter int width = 8,
   parameter int depth = 32
);
   localparam int ptrW = $clog2(depth);

   logic [width-1:0] dataIn;
   logic             insert;
   logic             del_pulse;
   logic             ptrLeft_pulse;
   logic             ptrRight_pulse;
   logic             eval_pulse;
   logic             eval_ack;
   logic [ptrW-1:0]  rd_addr;
   logic [width-1:0] rd_data;
   logic [ptrW:0]    size;
   logic [ptrW:0]    ptr;
   logic             full;
   logic             empty;
   logic             overflow;
   logic             eval_req;

   modport master (
      output dataIn, insert, del_pulse, ptrLeft_pulse, ptrRight_pulse,
             eval_pulse, eval_ack, rd_addr,
      input  rd_data, size, ptr, full, empty, overflow, eval_req
   );

   modport slave (
      input  dataIn, insert, del_pulse, ptrLeft_pulse, ptrRight_pulse,
             eval_pulse, eval_ack, rd_addr,
      output rd_data, size, ptr, full, empty, overflow, eval_req
   );
endinterface

// File: rtl/key_edge.sv
// One-bit rising-edge detector: turns a level held by the encoder into a
// single-cycle command pulse.
module key_edge (
   input  logic clock,
   input  logic reset,
   input  logic level,
   output logic pulse
);
   logic prev_q, prev_d;

   // NOTE: combinational logic uses blocking '=', clocked state uses '<='.
   always_comb prev_d = level;

   always_ff @(posedge clock) begin
      if (!reset) prev_q <= 1'b0;
      else        prev_q <= prev_d;
   end

   assign pulse = level & ~prev_q;
endmodule

// File: rtl/expr_buffer.sv
// Cursor-addressed token buffer with frozen-evaluation handshake.
// Define EXPR_CLEAR_ON_EVAL_EN to empty the buffer when the evaluator acks.
module expr_buffer
   import calc_pkg::*;
#(
   parameter int width = DEFAULT_WIDTH,
   parameter int depth = DEFAULT_DEPTH
) (
   input  logic          clock,
   input  logic          reset,
   expr_buffer_if.slave  bus
);
   localparam int ptrW = $clog2(depth);
   typedef logic [ptrW:0] cnt_t;

   logic ins_e, del_e, left_e, right_e, eval_e;

   key_edge u_ins   (.clock(clock), .reset(reset), .level(bus.insert),         .pulse(ins_e));
   key_edge u_del   (.clock(clock), .reset(reset), .level(bus.del_pulse),      .pulse(del_e));
   key_edge u_left  (.clock(clock), .reset(reset), .level(bus.ptrLeft_pulse),  .pulse(left_e));
   key_edge u_right (.clock(clock), .reset(reset), .level(bus.ptrRight_pulse), .pulse(right_e));
   key_edge u_eval  (.clock(clock), .reset(reset), .level(bus.eval_pulse),     .pulse(eval_e));

   state_e           state_q, state_d;
   logic [width-1:0] mem_q [depth];
   logic [width-1:0] mem_d [depth];
   cnt_t             size_q, size_d;
   cnt_t             ptr_q, ptr_d;
   logic             overflow_q, overflow_d;
   logic             eval_req_q, eval_req_d;
   logic [width-1:0] rd_data_q, rd_data_d;

   always_comb begin
      // NOTE: every _d starts as its _q so no branch can leave it unassigned (no latch).
      state_d    = state_q;
      mem_d      = mem_q;
      size_d     = size_q;
      ptr_d      = ptr_q;
      overflow_d = overflow_q;
      eval_req_d = eval_req_q;
      rd_data_d  = mem_q[bus.rd_addr];

      case (state_q)
         ST_IDLE: begin
            if (eval_e) begin
               state_d    = ST_EVAL;
               eval_req_d = 1'b1;
            end else if (del_e) begin
               if (ptr_q != '0) begin
                  // Remove the token just left of the cursor, closing the gap.
                  for (int i = 0; i < depth - 1; i++) begin
                     if (cnt_t'(i + 1) >= ptr_q && cnt_t'(i + 1) < size_q)
                        mem_d[i] = mem_q[i + 1];
                  end
                  size_d     = size_q - cnt_t'(1);
                  ptr_d      = ptr_q - cnt_t'(1);
                  overflow_d = 1'b0;
               end
            end else if (ins_e) begin
               if (size_q < cnt_t'(depth)) begin
                  for (int i = 1; i < depth; i++) begin
                     if (cnt_t'(i) > ptr_q && cnt_t'(i) <= size_q)
                        mem_d[i] = mem_q[i - 1];
                  end
                  mem_d[ptr_q[ptrW-1:0]] = bus.dataIn;
                  size_d = size_q + cnt_t'(1);
                  ptr_d  = ptr_q + cnt_t'(1);
               end else begin
                  overflow_d = 1'b1;
               end
            end else if (left_e) begin
               if (ptr_q != '0) ptr_d = ptr_q - cnt_t'(1);
            end else if (right_e) begin
               if (ptr_q < size_q) ptr_d = ptr_q + cnt_t'(1);
            end
         end
         ST_EVAL: begin
            if (bus.eval_ack) begin
               state_d    = ST_IDLE;
               eval_req_d = 1'b0;
`ifdef EXPR_CLEAR_ON_EVAL_EN
               size_d     = '0;
               ptr_d      = '0;
               overflow_d = 1'b0;
`else
               size_d     = size_q;
               ptr_d      = ptr_q;
`endif
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         size_q     <= '0;
         ptr_q      <= '0;
         overflow_q <= 1'b0;
         eval_req_q <= 1'b0;
         rd_data_q  <= '0;
         // NOTE: the token store is reset-cleared, so it maps to flops rather than a RAM.
         for (int i = 0; i < depth; i++) mem_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         size_q     <= size_d;
         ptr_q      <= ptr_d;
         overflow_q <= overflow_d;
         eval_req_q <= eval_req_d;
         rd_data_q  <= rd_data_d;
         mem_q      <= mem_d;
      end
   end

   assign bus.rd_data  = rd_data_q;
   assign bus.size     = size_q;
   assign bus.ptr      = ptr_q;
   assign bus.full     = (size_q == cnt_t'(depth));
   assign bus.empty    = (size_q == '0);
   assign bus.overflow = overflow_q;
   assign bus.eval_req = eval_req_q;
endmodule

// File: doc/expr_buffer.md
# expr_buffer

Token buffer with cursor that sits directly downstream of the keyboard encoder. It turns the encoder's level-held `insert` / `del_pulse` / `ptrLeft_pulse` / `ptrRight_pulse` / `eval_pulse` signals into single-shot edit commands. It stores the expression as a sequence of `width`-bit token codes, with cursor-relative insert and delete. It hands the frozen expression to the evaluator through a request/acknowledge handshake and a synchronous read port.

## Interface
- `width`, 8, token code width (matches encoder `dataIn`)
- `depth`, 32, maximum tokens stored
- `ptrW`, `$clog2(depth)`, index width; `size`/`ptr` use `ptrW+1` bits
- `clock`  in  1  single clock; all logic on posedge
- `reset`  in  1  synchronous, active-low reset
- `dataIn`  in  width  token code from encoder
- `insert`, `del_pulse`, `ptrLeft_pulse`, `ptrRight_pulse`, `eval_pulse`  in  1 each  level inputs, high while key held
- `eval_ack`  in  1  evaluator done; single-cycle pulse
- `rd_addr`  in  ptrW  evaluator/display read index
- `rd_data`  out  width  token at `rd_addr`, registered
- `size`  out  ptrW+1  tokens stored, 0..depth
- `ptr`  out  ptrW+1  cursor, 0..size; insert point is before index `ptr`
- `full`, `empty`  out  1  `size==depth`, `size==0`
- `overflow`  out  1  sticky: an insert was dropped because full
- `eval_req`  out  1  high while the buffer is frozen for evaluation

## Operation
- Rising-edge detect on each of the five level inputs: `cmd = level & ~prev`. `prev` registers update every cycle, including during EVAL, so a held key never re-fires.
- Simultaneous edges in one cycle: only the highest-priority command executes; the others are discarded. Priority order: eval > del > insert > ptrLeft > ptrRight.
- INSERT (`size<depth`):
  - `buf[ptr..size-1]` shifts up one, in parallel in one cycle.
  - `buf[ptr] <= dataIn` (sampled in the same cycle the edge is detected).
  - `size++`, `ptr++`.
- INSERT when full: buffer unchanged; `overflow <= 1`.
- DELETE (`ptr>0`):
  - `buf[ptr..size-1]` shifts down one.
  - `size--`, `ptr--`.
  - `overflow <= 0`.
- DELETE with `ptr==0`: no-op.
- LEFT: `ptr--` if `ptr>0`, else no-op. RIGHT: `ptr++` if `ptr<size`, else no-op.
- FSM states: IDLE, EVAL.
  - IDLE: eval edge -> EVAL, `eval_req<=1`. Allowed even if empty; the evaluator handles an empty buffer.
  - EVAL: all edit edges ignored. `eval_ack` -> IDLE, `eval_req<=0`.
  - `eval_ack` seen in IDLE is ignored.
- Read port: `rd_data <= buf[rd_addr]` every cycle, in any state. Reading at `rd_addr>=size` returns stale contents; callers bound the read by `size`.
- Unused entries are not cleared on delete.

## Timing
- Reset (`reset==0` at posedge): `size=0`, `ptr=0`, `overflow=0`, `eval_req=0`, `rd_data=0`, all `prev=0`, state IDLE, buffer cleared to 0. Reset applied mid-EVAL abandons the evaluation.
- Command latency: an input sampled high at posedge k, with `prev` low, updates `buf`/`size`/`ptr`/flags at posedge k. The new values are visible in the cycle after k.
- `full`/`empty` are combinational from the `size` register.
- Read latency: 1 cycle (`rd_addr` at posedge k -> `rd_data` valid after k). A write at posedge k and a read of the same address at posedge k return the old value.
- `eval_req` rises at the posedge after the eval edge is sampled. It falls at the posedge that samples `eval_ack` high.
- Minimum spacing between accepted edits: 2 cycles, because each key must go low then high again.

## Configuration
- `EXPR_CLEAR_ON_EVAL_EN` defined: on leaving EVAL via `eval_ack`, `size<=0`, `ptr<=0`, `overflow<=0`; the buffer is ready for a new expression.
- Not defined: buffer contents, `size`, and `ptr` are retained after `eval_ack`, so the user can edit and re-evaluate.

## Structure
- Shared package `calc_pkg`: token code constants (digits, `OP_ADD`..`OP_DIV`, `OP_LB`/`OP_RB`, `OP_DECIMAL`, `OP_COMMA`, constants, functions), default `width`, and the FSM state enum.
- Sub-module `key_edge`: one-bit rising-edge detector with the same `clock`/`reset`, instantiated five times.

## Test plan
- Reset, then insert 0x01, 0x2A, 0x02 (each held 3 cycles, 2 low cycles between) -> `size=3`, `ptr=3`; reads 0..2 give 0x01, 0x2A, 0x02; exactly one token per press.
- From `[01,2A,02]`, `ptr=3`: LEFT ×2 then insert 0x1E -> buffer `[01,1E,2A,02]`, `ptr=2`, `size=4`. Then DELETE -> `[01,2A,02]`, `ptr=1`.
- Boundaries:
  - LEFT at `ptr=0` -> no change.
  - RIGHT at `ptr=size` -> no change.
  - DELETE at `ptr=0` -> no change.
  - 33 inserts with `depth=32` -> `size=32`, `full=1`, `overflow=1`, contents unchanged by the 33rd.
- `insert` and `del_pulse` rise in the same cycle -> only the delete executes; holding both afterwards causes nothing further.
- Eval:
  - eval edge -> `eval_req=1` next cycle.
  - Inserts and LEFT during EVAL -> ignored.
  - `eval_ack` pulse -> `eval_req=0`; `size` is 0 with `EXPR_CLEAR_ON_EVAL_EN`, unchanged without it.
- Assert `reset` low mid-EVAL with `size=5` -> next cycle `size=0`, `ptr=0`, `eval_req=0`, state IDLE.
